stage_mem: RTL and testbench

- MEM stage of the five-stage pipeline CPU. It consumes the EX stage's results (ALU output, store data, condition, instruction, new PC) and holds them in the EX/MEM register.
- Performs word loads and stores over a req/ack data-memory port and presents the MEM/WB bundle to write-back.
- Back-pressures EX with in_ready while a memory access is outstanding.

---
 rtl/stage_mem_pkg.sv | 19 +
 rtl/stage_mem_dmem_access_fsm.sv | 74 +++++++
 rtl/stage_mem.sv | 138 +++++++++++++
 tb/tb_stage_mem.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// stage_mem shared types: FSM state encoding, word-align mask and the
// EX/MEM control bundle.
package stage_mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic condition;
   } ex_mem_ctrl_t;

endpackage

// File: rtl/stage_mem_dmem_access_fsm.sv
// Data-memory access sequencer: owns the request holding registers,
// the pending state and the sticky kill applied by a mid-access flush.
module dmem_access_fsm
   import stage_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              start_we,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [DATA_W-1:0] start_wdata,
   input  logic              flush,
   input  logic              dmem_ack,
   output logic              pending,
   output logic              done,
   output logic              killed,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata
);

   localparam logic [ADDR_W-1:0] ADDR_MASK =
      ~ADDR_W'(WORD_ALIGN_MASK);

   mem_state_e state_q, state_d;
   logic       kill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ACCESS;
         ACCESS:  if (dmem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         kill_q     <= 1'b0;
      end else begin
         if (start) begin
            dmem_we    <= start_we;
            dmem_addr  <= start_addr & ADDR_MASK;
            dmem_wdata <= start_wdata;
         end
         // Kill survives until the bus completes, then clears.
         kill_q <= (state_q == ACCESS) & ~dmem_ack
                   & (kill_q | flush);
      end
   end

   always_comb begin
      dmem_req = (state_q == ACCESS);
      pending  = dmem_req;
      done     = dmem_req & dmem_ack;
      killed   = kill_q | flush;
   end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: EX/MEM capture, word load/store over req/ack and
// the MEM/WB bundle. Option: STAGE_MEM_MISALIGN_TRAP_EN.
module stage_mem
   import stage_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic              cs_mem_read,
   input  logic              cs_mem_write,
   input  logic              cs_reg_write,
   input  logic [DATA_W-1:0] in_inst,
   input  logic [DATA_W-1:0] in_new_pc,
   input  logic [DATA_W-1:0] in_alu_output,
   input  logic [DATA_W-1:0] in_reg_data_b,
   input  logic              in_condition,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic [DATA_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_new_pc,
   output logic [DATA_W-1:0] out_alu_output,
   output logic [DATA_W-1:0] out_mem_data,
   output logic              out_condition,
   output logic              out_reg_write,
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
   output logic              out_misalign,
`endif
   output logic              out_valid
);

   logic              accept, is_mem, mis;
   logic              issue, fast;
   logic              pending, done, killed;
   ex_mem_ctrl_t      ctrl_q;
   logic [DATA_W-1:0] inst_q, pc_q, alu_q;

   assign in_ready = ~pending;
   assign accept   = in_valid & in_ready & ~flush;
   assign is_mem   = cs_mem_read | cs_mem_write;

`ifdef STAGE_MEM_MISALIGN_TRAP_EN
   assign mis = is_mem & (in_alu_output[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   // Trapped misaligned ops retire like ALU ops and never touch the bus.
   assign issue = accept & is_mem & ~mis;
   assign fast  = accept & ~issue;

   dmem_access_fsm #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (issue),
      .start_we    (cs_mem_write),
      .start_addr  (in_alu_output[ADDR_W-1:0]),
      .start_wdata (in_reg_data_b),
      .flush       (flush),
      .dmem_ack    (dmem_ack),
      .pending     (pending),
      .done        (done),
      .killed      (killed),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         inst_q <= '0;
         pc_q   <= '0;
         alu_q  <= '0;
      end else if (accept) begin
         ctrl_q <= '{mem_read:  cs_mem_read,
                     mem_write: cs_mem_write,
                     reg_write: cs_reg_write,
                     condition: in_condition};
         inst_q <= in_inst;
         pc_q   <= in_new_pc;
         alu_q  <= in_alu_output;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_inst       <= '0;
         out_new_pc     <= '0;
         out_alu_output <= '0;
         out_mem_data   <= '0;
         out_condition  <= 1'b0;
         out_reg_write  <= 1'b0;
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
         out_misalign   <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         if (fast) begin
            out_valid      <= 1'b1;
            out_inst       <= in_inst;
            out_new_pc     <= in_new_pc;
            out_alu_output <= in_alu_output;
            out_condition  <= in_condition;
            out_reg_write  <= cs_reg_write & ~mis;
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
            out_misalign   <= mis;
`endif
         end else if (done & ~killed) begin
            out_valid      <= 1'b1;
            out_inst       <= inst_q;
            out_new_pc     <= pc_q;
            out_alu_output <= alu_q;
            out_condition  <= ctrl_q.condition;
            out_reg_write  <= ctrl_q.reg_write;
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
            out_misalign   <= 1'b0;
`endif
            if (ctrl_q.mem_read & ~ctrl_q.mem_write)
               out_mem_data <= dmem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed scenarios plus a random
// instruction stream against a transaction-level reference model.
module tb_stage_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        cs_mem_read = 1'b0;
   logic        cs_mem_write = 1'b0;
   logic        cs_reg_write = 1'b0;
   logic [31:0] in_inst = '0;
   logic [31:0] in_new_pc = '0;
   logic [31:0] in_alu_output = '0;
   logic [31:0] in_reg_data_b = '0;
   logic        in_condition = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic [31:0] out_inst, out_new_pc, out_alu_output, out_mem_data;
   logic        out_condition, out_reg_write, out_valid;
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
   logic        out_misalign;
`endif

   int n_chk = 0;
   int n_pass = 0;

   // Reference model of the MEM/WB registers.
   logic [31:0] e_inst, e_pc, e_alu, e_md;
   logic        e_cond, e_rw, e_mis;

   always #5 clk = ~clk;

   stage_mem dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .flush          (flush),
      .cs_mem_read    (cs_mem_read),
      .cs_mem_write   (cs_mem_write),
      .cs_reg_write   (cs_reg_write),
      .in_inst        (in_inst),
      .in_new_pc      (in_new_pc),
      .in_alu_output  (in_alu_output),
      .in_reg_data_b  (in_reg_data_b),
      .in_condition   (in_condition),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_rdata     (dmem_rdata),
      .dmem_ack       (dmem_ack),
      .out_inst       (out_inst),
      .out_new_pc     (out_new_pc),
      .out_alu_output (out_alu_output),
      .out_mem_data   (out_mem_data),
      .out_condition  (out_condition),
      .out_reg_write  (out_reg_write),
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
      .out_misalign   (out_misalign),
`endif
      .out_valid      (out_valid)
   );

   function automatic logic [130:0] exp_b();
      return {e_mis, e_inst, e_pc, e_alu, e_md, e_cond, e_rw};
   endfunction

   function automatic logic [130:0] got_b();
      logic m;
      m = 1'b0;
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
      m = out_misalign;
`endif
      return {m, out_inst, out_new_pc, out_alu_output,
              out_mem_data, out_condition, out_reg_write};
   endfunction

   task automatic model_reset();
      e_inst = '0; e_pc = '0; e_alu = '0; e_md = '0;
      e_cond = 1'b0; e_rw = 1'b0; e_mis = 1'b0;
   endtask

   // One instruction from issue to retirement plus one idle cycle.
   task automatic run_op(input logic rd, input logic wr,
                         input logic rw, input logic cond,
                         input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] b,
                         input logic [31:0] rdata, input int waits,
                         input int flush_at);
      logic mis, kill;
      mis = 1'b0;
      kill = 1'b0;
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
      mis = (rd | wr) && (alu[1:0] != 2'b00);
`endif
      n_chk++;
      if (in_ready !== 1'b1)
         $display("FAIL ready_pre: got %b want 1", in_ready);
      else n_pass++;
      in_valid = 1'b1; cs_mem_read = rd; cs_mem_write = wr;
      cs_reg_write = rw; in_condition = cond; in_inst = inst;
      in_new_pc = pc; in_alu_output = alu; in_reg_data_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; cs_mem_read = 1'b0; cs_mem_write = 1'b0;
      in_inst = $urandom; in_alu_output = $urandom;
      in_reg_data_b = $urandom; in_new_pc = $urandom;
      if (!(rd | wr) || mis) begin
         e_inst = inst; e_pc = pc; e_alu = alu; e_cond = cond;
         e_rw = rw & ~mis; e_mis = mis;
         n_chk++;
         if ({dmem_req, in_ready, out_valid} !== 3'b011)
            $display("FAIL fast_ctl: req/ready/valid got %b want 011",
                     {dmem_req, in_ready, out_valid});
         else n_pass++;
      end else begin
         for (int i = 0; i <= waits; i++) begin
            n_chk++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata,
                 in_ready, out_valid} !==
                {1'b1, wr, alu & 32'hFFFF_FFFC, b, 2'b00})
               $display("FAIL req_cyc%0d: got %b %b %h %h %b %b want 1 %b %h %h 0 0",
                        i, dmem_req, dmem_we, dmem_addr, dmem_wdata,
                        in_ready, out_valid, wr,
                        alu & 32'hFFFF_FFFC, b);
            else n_pass++;
            dmem_ack = (i == waits);
            dmem_rdata = (i == waits) ? rdata : $urandom;
            flush = (i == flush_at);
            if (i == flush_at) kill = 1'b1;
            @(posedge clk); #1;
            dmem_ack = 1'b0; flush = 1'b0;
         end
         if (!kill) begin
            e_inst = inst; e_pc = pc; e_alu = alu; e_cond = cond;
            e_rw = rw; e_mis = 1'b0;
            if (rd && !wr) e_md = rdata;
         end
         n_chk++;
         if ({dmem_req, in_ready, out_valid} !== {2'b01, ~kill})
            $display("FAIL mem_done: req/ready/valid got %b want %b",
                     {dmem_req, in_ready, out_valid}, {2'b01, ~kill});
         else n_pass++;
      end
      n_chk++;
      if (got_b() !== exp_b())
         $display("FAIL bundle: got %h want %h", got_b(), exp_b());
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if ({out_valid, dmem_req, got_b()} !== {2'b00, exp_b()})
         $display("FAIL pulse_hold: got %b %b %h want 0 0 %h",
                  out_valid, dmem_req, got_b(), exp_b());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #12;
      n_chk++;
      if ({out_valid, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           in_ready, got_b()} !== {5'b00000, 64'h0, 1'b1, exp_b()})
         $display("FAIL reset: valid %b req %b ready %b bundle %h want 0 0 1 0",
                  out_valid, dmem_req, in_ready, got_b());
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      run_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0033, 32'h0000_0104,
             32'h0000_0010, 32'h0, 32'h0, 0, -1);
   endtask

   task automatic test_load();
      run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0400_2003, 32'h0000_0108,
             32'h0000_0040, 32'h5555_AAAA, 32'hDEAD_BEEF, 2, -1);
   endtask

   task automatic test_store();
      run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h00B2_2223, 32'h0000_010C,
             32'h0000_0044, 32'h1234_5678, 32'hCAFE_F00D, 0, -1);
   endtask

   task automatic test_both_rw();
      run_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0777, 32'h0000_0110,
             32'h0000_0048, 32'hA5A5_5A5A, 32'h0BAD_0BAD, 1, -1);
   endtask

   task automatic test_flush_access();
      run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1111, 32'h0000_0200,
             32'h0000_0050, 32'h0, 32'h7777_7777, 3, 1);
      run_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2222, 32'h0000_0204,
             32'h0000_0099, 32'h0, 32'h0, 0, -1);
      run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3333, 32'h0000_0208,
             32'h0000_0060, 32'h0, 32'h6666_6666, 2, 2);
   endtask

   task automatic test_flush_incoming();
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; flush = 1'b1; cs_mem_read = (k == 0);
         cs_reg_write = 1'b1; in_alu_output = 32'h0000_0100;
         in_inst = 32'hFFFF_0000; in_new_pc = 32'h0000_0300;
         @(posedge clk); #1;
         in_valid = 1'b0; flush = 1'b0; cs_mem_read = 1'b0;
         n_chk++;
         if ({dmem_req, out_valid, in_ready, got_b()} !==
             {3'b001, exp_b()})
            $display("FAIL flush_in%0d: req %b valid %b ready %b want 0 0 1",
                     k, dmem_req, out_valid, in_ready);
         else n_pass++;
      end
   endtask

   task automatic test_stray_ack();
      dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      n_chk++;
      if ({dmem_req, out_valid, in_ready, got_b()} !==
          {3'b001, exp_b()})
         $display("FAIL stray_ack: req %b valid %b bundle %h want 0 0 %h",
                  dmem_req, out_valid, got_b(), exp_b());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         in_valid = 1'b1; cs_reg_write = i[0]; in_condition = i[1];
         in_inst = 32'h1000_0000 + i; in_new_pc = 32'h400 + 4 * i;
         in_alu_output = a;
         @(posedge clk); #1;
         e_inst = 32'h1000_0000 + i; e_pc = 32'h400 + 4 * i;
         e_alu = a; e_rw = i[0]; e_cond = i[1]; e_mis = 1'b0;
         n_chk++;
         if ({out_valid, in_ready, got_b()} !== {2'b11, exp_b()})
            $display("FAIL b2b%0d: valid %b ready %b got %h want %h",
                     i, out_valid, in_ready, got_b(), exp_b());
         else n_pass++;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b0)
         $display("FAIL b2b_end: valid got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_misalign();
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
      run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4444, 32'h0000_0500,
             32'h0000_0042, 32'h0, 32'h0, 0, -1);
`else
      run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4444, 32'h0000_0500,
             32'h0000_0042, 32'h0, 32'h2468_ACE0, 1, -1);
`endif
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; cs_mem_read = 1'b1; cs_reg_write = 1'b1;
      in_alu_output = 32'h0000_0080;
      @(posedge clk); #1;
      in_valid = 1'b0; cs_mem_read = 1'b0;
      n_chk++;
      if (dmem_req !== 1'b1)
         $display("FAIL rst_mid_req: got %b want 1", dmem_req);
      else n_pass++;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, out_valid,
           in_ready, got_b()} !== {2'b00, 64'h0, 2'b01, exp_b()})
         $display("FAIL rst_mid: req %b addr %h valid %b ready %b bundle %h want 0 0 0 1 0",
                  dmem_req, dmem_addr, out_valid, in_ready, got_b());
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if ({in_ready, dmem_req} !== 2'b10)
         $display("FAIL rst_rel: ready/req got %b want 10",
                  {in_ready, dmem_req});
      else n_pass++;
   endtask

   task automatic test_random();
      int kind, w, f;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         w = $urandom_range(0, 3);
         f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, w) : -1;
         run_op(kind == 1 || kind == 3, kind == 2 || kind == 3,
                1'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, $urandom, $urandom, w, f);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_both_rw();
      test_flush_access();
      test_flush_incoming();
      test_stray_ack();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
